uart_tx_fifo: RTL and testbench

Byte buffer that sits directly upstream of the uart transmitter. Host logic writes bytes at any rate up to one per clock. The block drains them in order into the uart's send_request/tx_data handshake, one byte per frame, pacing on tx_busy/tx_done. This lets software-side logic burst a message without polling the transmitter per byte.

---
 rtl/uart_tx_fifo_if.sv | 49 ++++
 rtl/uart_tx_fifo.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_tx_fifo_if
//
// Groups every non-clock signal of uart_tx_fifo into one bundle.
//
// The "slave" modport is the FIFO itself.
// The "master" modport is its environment, which is both:
//   - the host that writes bytes, and
//   - the uart transmitter that acknowledges frames.
//
// Signals:
//   wr_en, wr_data  host write strobe and byte
//   flush           synchronous clear of queued bytes
//   full, empty     occupancy flags decoded from count
//   count           bytes queued, excluding the in-flight byte
//   overflow        one-cycle pulse when a write is dropped because full
//   send_request    one-cycle pulse that starts a uart frame
//   tx_data         byte for the uart, held from request until tx_done
//   tx_busy         uart is sending a frame
//   tx_done         uart finished a frame (one-cycle pulse)
// ---------------------------------------------------------------------------
interface uart_tx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              wr_en;
    logic [7:0]        wr_data;
    logic              flush;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              send_request;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic              tx_done;

    modport slave (
        input  wr_en, wr_data, flush, tx_busy, tx_done,
        output full, empty, count, overflow, send_request, tx_data
    );

    modport master (
        output wr_en, wr_data, flush, tx_busy, tx_done,
        input  full, empty, count, overflow, send_request, tx_data
    );
endinterface

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte queue that sits in front of a uart transmitter.
//
// The host can write up to one byte per clock. The block hands the bytes to
// the uart in order, one per frame, through the send_request/tx_data
// handshake. It paces itself on tx_busy and tx_done.
//
// Ports:
//   clk      system clock, all logic on posedge
//   reset_n  asynchronous active-low reset
//   bus      uart_tx_fifo_if.slave:
//              host side : wr_en, wr_data, flush, full, empty, count,
//                          overflow
//              uart side : send_request, tx_data, tx_busy, tx_done
//
// Parameters:
//   DEPTH    number of byte entries; power of two, minimum 2
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    uart_tx_fifo_if.slave    bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_FULL = DEPTH[ADDR_W:0];

    typedef enum logic {
        ST_IDLE,
        ST_WAIT_DONE
    } state_t;

    // Storage is deliberately left without a reset.
    logic [7:0]          r_mem [DEPTH];

    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic                r_overflow;
    logic                r_send_request;
    logic [7:0]          r_tx_data;
    state_t              r_state;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_drop;
    logic                w_pop;
    logic [ADDR_W:0]     w_count_next;
    state_t              w_state_next;

    // Occupancy flags come from the count at the start of the cycle.
    // This means a pop in the same cycle cannot make room for a write.
    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);

    // A write during flush is dropped silently: it is neither stored
    // nor reported as an overflow.
    assign w_push = bus.wr_en && !w_full && !bus.flush;
    assign w_drop = bus.wr_en &&  w_full && !bus.flush;

    // -----------------------------------------------------------------------
    // Frame FSM: next state and pop decision
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A tx_done that arrives while idle has no effect.
                if (!w_empty && !bus.tx_busy && !bus.flush) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.tx_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Count update
    // -----------------------------------------------------------------------
    always_comb begin
        w_count_next = r_count;
        if (bus.flush) begin
            w_count_next = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + CNT_ONE;
                2'b01:   w_count_next = r_count - CNT_ONE;
                default: w_count_next = r_count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Pointers, count and the registered uart-side outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_overflow     <= 1'b0;
            r_send_request <= 1'b0;
            r_tx_data      <= 8'h00;
        end else begin
            r_count        <= w_count_next;
            r_overflow     <= w_drop;
            r_send_request <= w_pop;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end

            // Flush discards everything queued by moving the read pointer
            // onto the write pointer. Because w_push is gated by flush, the
            // write pointer does not move in this cycle.
            if (bus.flush) begin
                r_rd_ptr <= r_wr_ptr;
            end else if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end

            // tx_data only changes on a pop, so it stays stable for the
            // whole frame, including across a flush.
            if (w_pop) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Byte storage
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.send_request = r_send_request;
    assign bus.tx_data      = r_tx_data;

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Bench for uart_tx_fifo.
//
// The bench drives inputs on the falling edge and samples outputs on the
// falling edge.
//
// A small uart model answers each send_request. It holds tx_busy for a
// frame, then pulses tx_done. Every requested byte is compared against
// the scoreboard queue of bytes the bench expects to be accepted.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] exp_q [$];

    // Uart model controls and state.
    logic       force_busy  = 1'b1;
    logic       hold        = 1'b0;
    logic       m_busy      = 1'b0;
    int         m_frame     = 6;
    int         m_cnt       = 0;
    logic [7:0] m_cur       = 8'h00;
    int         m_reqs      = 0;
    int         since_done  = 0;
    logic       gap_pending = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Uart model and scoreboard consumer
    // -----------------------------------------------------------------------
    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_busy      = 1'b0;
                m_cnt       = 0;
                gap_pending = 1'b0;
                bus.tx_done = 1'b0;
                bus.tx_busy = force_busy;
            end else begin
                #1;
                bus.tx_done = 1'b0;
                if (gap_pending) since_done++;
                if (bus.send_request) begin
                    m_reqs++;
                    check("req_pulse_single", 32'(m_busy), 32'd0);
                    check("req_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) check("req_tx_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
                    if (gap_pending) begin
                        check("b2b_gap", 32'(since_done), 32'd2);
                        gap_pending = 1'b0;
                    end
                    m_busy = 1'b1;
                    m_cnt  = m_frame;
                    m_cur  = bus.tx_data;
                end else if (m_busy) begin
                    check("tx_data_hold", 32'(bus.tx_data), 32'(m_cur));
                    if (!hold) begin
                        m_cnt--;
                        if (m_cnt == 0) begin
                            bus.tx_done = 1'b1;
                            m_busy      = 1'b0;
                            if (exp_q.size() != 0) begin
                                gap_pending = 1'b1;
                                since_done  = 0;
                            end
                        end
                    end
                end
                bus.tx_busy = m_busy | force_busy;
            end
        end
    end

    task automatic write_burst(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(base + 8'(i));
            exp_q.push_back(8'(base + 8'(i)));
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int k = 0;
        while (k < budget && !(exp_q.size() == 0 && !m_busy && bus.empty)) begin
            @(negedge clk);
            k++;
        end
        check({nm, "_drained"}, 32'(exp_q.size() == 0 && !m_busy && bus.empty), 32'd1);
    endtask

    task automatic wait_reqs(input string nm, input int target, input int budget);
        int k = 0;
        while (k < budget && m_reqs < target) begin
            @(negedge clk);
            k++;
        end
        check({nm, "_req_seen"}, 32'(m_reqs >= target), 32'd1);
    endtask

    typedef struct {
        logic          wr_en;
        logic [7:0]    data;
        logic          flush;
        logic [CW-1:0] count;
        logic          full;
        logic          empty;
        logic          ovf;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int reqs0;

        // Table: the uart is held busy, so only writes and flushes move count.
        for (int i = 0; i < 16; i++) begin
            vecs[i].wr_en = 1'b1;
            vecs[i].data  = 8'(8'h10 + 8'(i));
            vecs[i].flush = 1'b0;
            vecs[i].count = CW'(i + 1);
            vecs[i].full  = (i == 15);
            vecs[i].empty = 1'b0;
            vecs[i].ovf   = 1'b0;
        end
        vecs[16] = '{1'b1, 8'hEE, 1'b0, CW'(16), 1'b1, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 8'h00, 1'b0, CW'(16), 1'b1, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 8'hEF, 1'b1, CW'(0),  1'b0, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 8'h00, 1'b0, CW'(0),  1'b0, 1'b1, 1'b0};
        vecs[20] = '{1'b1, 8'h77, 1'b0, CW'(1),  1'b0, 1'b0, 1'b0};
        vecs[21] = '{1'b1, 8'h78, 1'b1, CW'(0),  1'b0, 1'b1, 1'b0};

        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.flush   = 1'b0;
        bus.tx_busy = 1'b1;
        bus.tx_done = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_count",    32'(bus.count),        32'd0);
        check("rst_empty",    32'(bus.empty),        32'd1);
        check("rst_full",     32'(bus.full),         32'd0);
        check("rst_overflow", 32'(bus.overflow),     32'd0);
        check("rst_send_req", 32'(bus.send_request), 32'd0);
        check("rst_tx_data",  32'(bus.tx_data),      32'd0);

        // Table-driven occupancy, overflow and flush.
        for (int i = 0; i < NV; i++) begin
            bus.wr_en   = vecs[i].wr_en;
            bus.wr_data = vecs[i].data;
            bus.flush   = vecs[i].flush;
            @(negedge clk);
            check($sformatf("vec%0d_count", i), 32'(bus.count),    32'(vecs[i].count));
            check($sformatf("vec%0d_full", i),  32'(bus.full),     32'(vecs[i].full));
            check($sformatf("vec%0d_empty", i), 32'(bus.empty),    32'(vecs[i].empty));
            check($sformatf("vec%0d_ovf", i),   32'(bus.overflow), 32'(vecs[i].ovf));
        end
        bus.wr_en = 1'b0;
        bus.flush = 1'b0;
        force_busy = 1'b0;
        repeat (4) @(negedge clk);
        check("table_no_request", 32'(m_reqs), 32'd0);

        // Single byte: request one cycle after count shows 1.
        m_frame = 6;
        exp_q.push_back(8'hD3);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hD3;
        @(negedge clk);
        bus.wr_en = 1'b0;
        check("single_count1",  32'(bus.count),        32'd1);
        check("single_req_lo",  32'(bus.send_request), 32'd0);
        @(negedge clk);
        check("single_req_hi",  32'(bus.send_request), 32'd1);
        check("single_tx_data", 32'(bus.tx_data),      32'hD3);
        check("single_count0",  32'(bus.count),        32'd0);
        @(negedge clk);
        check("single_req_pulse", 32'(bus.send_request), 32'd0);
        check("single_tx_hold",   32'(bus.tx_data),      32'hD3);
        wait_drain("single", 100);

        // Burst of 16: one byte pops early, so count peaks at 15.
        m_frame = 20;
        write_burst(8'h00, 16);
        check("burst_count_peak", 32'(bus.count), 32'd15);
        check("burst_not_full",   32'(bus.full),  32'd0);
        wait_drain("burst", 16 * 30 + 50);
        check("burst_empty", 32'(bus.empty), 32'd1);

        // Overflow: the uart stalls after the first pop.
        m_frame = 6;
        hold    = 1'b1;
        reqs0   = m_reqs;
        write_burst(8'h30, 1);
        wait_reqs("ovf_first", reqs0 + 1, 20);
        for (int i = 0; i < 17; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(8'h31 + 8'(i));
            if (i < 16) exp_q.push_back(8'(8'h31 + 8'(i)));
            @(negedge clk);
            check($sformatf("ovf%0d_count", i), 32'(bus.count),    32'((i < 16) ? i + 1 : 16));
            check($sformatf("ovf%0d_full", i),  32'(bus.full),     32'(i >= 15));
            check($sformatf("ovf%0d_pulse", i), 32'(bus.overflow), 32'(i == 16));
        end
        bus.wr_en = 1'b0;
        @(negedge clk);
        check("ovf_pulse_end", 32'(bus.overflow), 32'd0);
        check("ovf_count_16",  32'(bus.count),    32'd16);
        hold = 1'b0;
        wait_drain("ovf", 17 * 12 + 50);

        // Pointer wrap: two bursts of ten.
        write_burst(8'h90, 10);
        wait_drain("wrap1", 10 * 12 + 50);
        write_burst(8'hA0, 10);
        wait_drain("wrap2", 10 * 12 + 50);

        // Flush while the first of five bytes is in flight.
        hold  = 1'b1;
        reqs0 = m_reqs;
        write_burst(8'hB0, 5);
        wait_reqs("flush_first", reqs0 + 1, 20);
        check("flush_pre_count", 32'(bus.count), 32'd4);
        bus.flush = 1'b1;
        exp_q.delete();
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_count",   32'(bus.count),        32'd0);
        check("flush_empty",   32'(bus.empty),        32'd1);
        check("flush_tx_data", 32'(bus.tx_data),      32'hB0);
        check("flush_no_req",  32'(bus.send_request), 32'd0);
        hold = 1'b0;
        wait_drain("flush", 50);
        repeat (20) @(negedge clk);
        check("flush_req_total", 32'(m_reqs), 32'(reqs0 + 1));

        // Asynchronous reset between edges during a frame.
        hold  = 1'b1;
        reqs0 = m_reqs;
        write_burst(8'hC1, 2);
        wait_reqs("arst_first", reqs0 + 1, 20);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_count",    32'(bus.count),        32'd0);
        check("arst_empty",    32'(bus.empty),        32'd1);
        check("arst_full",     32'(bus.full),         32'd0);
        check("arst_overflow", 32'(bus.overflow),     32'd0);
        check("arst_send_req", 32'(bus.send_request), 32'd0);
        check("arst_tx_data",  32'(bus.tx_data),      32'd0);
        #2;
        reset_n = 1'b1;
        hold    = 1'b0;
        @(negedge clk);
        check("arst_post_overflow", 32'(bus.overflow),     32'd0);
        check("arst_post_send_req", 32'(bus.send_request), 32'd0);
        reqs0 = m_reqs;
        write_burst(8'h5A, 1);
        wait_drain("arst_5a", 50);
        check("arst_5a_sent", 32'(m_reqs), 32'(reqs0 + 1));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
